// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-through data cache sequencer with hit/miss statistics
module cache_ctrl #(
    parameter int ADDR_W  = 15,
    parameter int INDEX_W = 12,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;

    state_t             state, state_nxt;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem [LINES];
    logic [DATA_W-1:0]  data_mem [LINES];
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               fill;

    assign idx       = addr_q[INDEX_W-1:0];
    assign tag       = addr_q[ADDR_W-1:INDEX_W];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    assign fill      = (state == MEM_RD || state == MEM_WR) && mem_ack;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // state register; reset abandons any memory transaction at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // next-state: stores always go to memory, loads only on a miss
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:           state_nxt = cpu_req ? LOOKUP : IDLE;
            LOOKUP:         state_nxt = we_q ? MEM_WR : (hit ? RESP : MEM_RD);
            MEM_RD, MEM_WR: state_nxt = mem_ack ? RESP : state;
            RESP:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    // outputs decoded straight from the state register
    always_comb begin
        busy      = state != IDLE;
        cpu_ready = state == RESP;
        mem_req   = state == MEM_RD || state == MEM_WR;
        mem_we    = state == MEM_WR;
    end

    // request latch, valid bits, response data and saturating statistics
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valid      <= '0;
            cpu_rdata  <= '0;
            cpu_hit    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (state == LOOKUP) begin
                cpu_hit <= hit;
                if (hit && !we_q) cpu_rdata <= data_mem[idx];
                if (hit && ~&hit_count) hit_count <= hit_count + CNT_W'(1);
                if (!hit && ~&miss_count) miss_count <= miss_count + CNT_W'(1);
            end
            if (fill) begin
                valid[idx] <= 1'b1;
                if (!we_q) begin
                    cpu_rdata <= mem_rdata;
                    cpu_hit   <= 1'b0;
                end
            end
        end
    end

    // tag/data arrays are not reset; a fill or store allocation replaces the line
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= we_q ? wdata_q : mem_rdata;
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: randomized and directed checks of cache_ctrl against a line-level cache model
module tb_cache_ctrl;
    localparam int SAT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int chk = 0;
    int fails = 0;

    bit          mv[int];
    logic [2:0]  mt[int];
    logic [31:0] md[int];
    int          mh = 0;
    int          mm = 0;
    logic [31:0] mlast = '0;

    cache_ctrl #(.ADDR_W(15), .INDEX_W(12), .DATA_W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // reference cache: one entry per index holding tag and word; write-through with allocate
    task automatic model_step(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                              input logic [31:0] mrd, output logic [31:0] erd, output logic eh);
        int i = int'(addr[11:0]);
        logic [2:0] t = addr[14:12];
        eh = mv.exists(i) && mt[i] == t;
        if (eh) mh = (mh < SAT) ? mh + 1 : SAT;
        else    mm = (mm < SAT) ? mm + 1 : SAT;
        if (we) begin
            mv[i] = 1; mt[i] = t; md[i] = wd;
        end else if (eh) begin
            mlast = md[i];
        end else begin
            mv[i] = 1; mt[i] = t; md[i] = mrd; mlast = mrd;
        end
        erd = mlast;
    endtask

    task automatic model_reset();
        mv.delete(); mt.delete(); md.delete();
        mh = 0; mm = 0; mlast = '0;
    endtask

    // drives one request and plays the memory side: ack after wt extra cycles of mem_req
    task automatic access(input logic we, input logic [14:0] addr, input logic [31:0] wd,
                          input logic [31:0] mrd, input int wt, output logic [31:0] rd,
                          output logic hit, output int lat, output int reqn, output int bad);
        lat = -1; reqn = 0; bad = 0; rd = 'x; hit = 1'bx;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 15'($urandom); cpu_wdata = $urandom;
        for (int n = 1; n <= 100 && lat < 0; n++) begin
            @(negedge clk);
            mem_ack = 1'($urandom);
            mem_rdata = $urandom;
            if (mem_req) begin
                mem_ack = 1'b0;
                reqn++;
                if (mem_addr !== addr || mem_we !== we || (we && mem_wdata !== wd)) bad++;
                if (reqn == wt + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mrd;
                end
            end
            if (cpu_ready) begin
                lat = n; rd = cpu_rdata; hit = cpu_hit;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk++; if (cpu_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", cpu_ready); end
        chk++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        chk++; if (mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        chk++; if ({hit_count, miss_count} !== 8'h00) begin fails++; $display("FAIL reset_counts got %h/%h exp 0/0", hit_count, miss_count); end
        chk++; if (cpu_rdata !== 32'h0 || mem_addr !== 15'h0) begin fails++; $display("FAIL reset_data got %h/%h exp 0/0", cpu_rdata, mem_addr); end
        rst = 1'b1;
    endtask

    task automatic test_load_miss();
        logic [31:0] rd, erd; logic h, eh; int lat, reqn, bad;
        model_step(1'b0, 15'h1234, '0, 32'hDEADBEEF, erd, eh);
        access(1'b0, 15'h1234, '0, 32'hDEADBEEF, 3, rd, h, lat, reqn, bad);
        chk++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL miss_rdata got %h exp deadbeef", rd); end
        chk++; if (h !== 1'b0) begin fails++; $display("FAIL miss_hit got %b exp 0", h); end
        chk++; if (lat !== 6) begin fails++; $display("FAIL miss_latency got %0d exp 6", lat); end
        chk++; if (reqn !== 4 || bad !== 0) begin fails++; $display("FAIL miss_memreq got %0d cycles %0d bad exp 4 cycles 0 bad", reqn, bad); end
        chk++; if (miss_count !== 4'd1 || hit_count !== 4'd0) begin fails++; $display("FAIL miss_counts got %0d/%0d exp 0/1", hit_count, miss_count); end
    endtask

    task automatic test_load_hit();
        logic [31:0] rd, erd; logic h, eh; int lat, reqn, bad;
        model_step(1'b0, 15'h1234, '0, '0, erd, eh);
        access(1'b0, 15'h1234, '0, 32'h0BAD0BAD, 0, rd, h, lat, reqn, bad);
        chk++; if (rd !== 32'hDEADBEEF || h !== 1'b1) begin fails++; $display("FAIL hit_resp got %h/%b exp deadbeef/1", rd, h); end
        chk++; if (lat !== 2) begin fails++; $display("FAIL hit_latency got %0d exp 2", lat); end
        chk++; if (reqn !== 0) begin fails++; $display("FAIL hit_memreq got %0d exp 0", reqn); end
        chk++; if (hit_count !== 4'd1 || miss_count !== 4'd1) begin fails++; $display("FAIL hit_counts got %0d/%0d exp 1/1", hit_count, miss_count); end
    endtask

    task automatic test_conflict();
        logic [31:0] rd, erd; logic h, eh; int lat, reqn, bad;
        model_step(1'b0, 15'h5234, '0, 32'h11111111, erd, eh);
        access(1'b0, 15'h5234, '0, 32'h11111111, 1, rd, h, lat, reqn, bad);
        chk++; if (rd !== 32'h11111111 || h !== 1'b0 || reqn !== 2) begin fails++; $display("FAIL conflict_first got %h/%b/%0d exp 11111111/0/2", rd, h, reqn); end
        model_step(1'b0, 15'h1234, '0, 32'h22222222, erd, eh);
        access(1'b0, 15'h1234, '0, 32'h22222222, 2, rd, h, lat, reqn, bad);
        chk++; if (rd !== 32'h22222222 || h !== 1'b0 || reqn !== 3) begin fails++; $display("FAIL conflict_second got %h/%b/%0d exp 22222222/0/3", rd, h, reqn); end
        chk++; if (miss_count !== 4'd3) begin fails++; $display("FAIL conflict_misses got %0d exp 3", miss_count); end
    endtask

    task automatic test_store();
        logic [31:0] rd, erd; logic h, eh; int lat, reqn, bad;
        model_step(1'b1, 15'h0007, 32'hCAFEF00D, '0, erd, eh);
        access(1'b1, 15'h0007, 32'hCAFEF00D, 32'h55555555, 2, rd, h, lat, reqn, bad);
        chk++; if (reqn !== 3 || bad !== 0) begin fails++; $display("FAIL store_memreq got %0d cycles %0d bad exp 3 cycles 0 bad", reqn, bad); end
        chk++; if (h !== 1'b0 || lat !== 5) begin fails++; $display("FAIL store_resp got hit %b lat %0d exp 0/5", h, lat); end
        chk++; if (rd !== 32'h22222222) begin fails++; $display("FAIL store_rdata_held got %h exp 22222222", rd); end
        model_step(1'b0, 15'h0007, '0, '0, erd, eh);
        access(1'b0, 15'h0007, '0, 32'h0BAD0BAD, 0, rd, h, lat, reqn, bad);
        chk++; if (rd !== 32'hCAFEF00D || h !== 1'b1 || reqn !== 0) begin fails++; $display("FAIL store_then_load got %h/%b/%0d exp cafef00d/1/0", rd, h, reqn); end
    endtask

    task automatic test_back_to_back();
        int q[$];
        int reqs = 0;
        logic [31:0] erd; logic eh;
        mem_ack = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (mem_req) reqs++;
            if (cpu_ready) begin
                q.push_back(n);
                chk++; if (cpu_rdata !== 32'h22222222 || cpu_hit !== 1'b1) begin fails++; $display("FAIL b2b_resp got %h/%b exp 22222222/1", cpu_rdata, cpu_hit); end
            end
            if (n == 12) cpu_req = 1'b0;
        end
        repeat (4) model_step(1'b0, 15'h1234, '0, '0, erd, eh);
        chk++; if (q.size() !== 4 || reqs !== 0) begin fails++; $display("FAIL b2b_count got %0d pulses %0d reqs exp 4/0", q.size(), reqs); end
        for (int i = 0; i < q.size(); i++) begin
            chk++; if (q[i] !== 2 + 3 * i) begin fails++; $display("FAIL b2b_spacing pulse %0d got cycle %0d exp %0d", i, q[i], 2 + 3 * i); end
        end
        @(negedge clk);
        chk++; if (busy !== 1'b0 || hit_count !== 4'(mh)) begin fails++; $display("FAIL b2b_after got busy %b hits %0d exp 0/%0d", busy, hit_count, mh); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd, mrd; logic h, eh, we; logic [14:0] a; int lat, reqn, bad, wt;
        for (int k = 0; k < 40; k++) begin
            a = {3'($urandom_range(0, 3)), 12'h010 + 12'($urandom_range(0, 3))};
            we = ($urandom_range(0, 9) < 3);
            wd = $urandom; mrd = $urandom; wt = $urandom_range(0, 3);
            model_step(we, a, wd, mrd, erd, eh);
            access(we, a, wd, mrd, wt, rd, h, lat, reqn, bad);
            chk++; if (rd !== erd || h !== eh) begin fails++; $display("FAIL rnd_resp %0d addr %h got %h/%b exp %h/%b", k, a, rd, h, erd, eh); end
            chk++; if (lat !== ((eh && !we) ? 2 : 3 + wt)) begin fails++; $display("FAIL rnd_latency %0d got %0d exp %0d", k, lat, (eh && !we) ? 2 : 3 + wt); end
            chk++; if (reqn !== ((eh && !we) ? 0 : wt + 1) || bad !== 0) begin fails++; $display("FAIL rnd_memreq %0d got %0d cycles %0d bad exp %0d/0", k, reqn, bad, (eh && !we) ? 0 : wt + 1); end
            chk++; if (hit_count !== 4'(mh) || miss_count !== 4'(mm)) begin fails++; $display("FAIL rnd_counts %0d got %0d/%0d exp %0d/%0d", k, hit_count, miss_count, mh, mm); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] rd, erd; logic h, eh; int lat, reqn, bad, n;
        mem_ack = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0ABC;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL rstmid_stalled got req %b we %b exp 1/0", mem_req, mem_we); end
        #2 rst = 1'b0;
        #1;
        chk++; if (mem_req !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_abort got req %b busy %b exp 0/0", mem_req, busy); end
        chk++; if (hit_count !== 4'd0 || miss_count !== 4'd0 || cpu_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_clear got %0d/%0d/%h exp 0/0/0", hit_count, miss_count, cpu_rdata); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        model_step(1'b0, 15'h1234, '0, 32'h12345678, erd, eh);
        access(1'b0, 15'h1234, '0, 32'h12345678, 1, rd, h, lat, reqn, bad);
        chk++; if (h !== 1'b0 || reqn !== 2 || rd !== 32'h12345678) begin fails++; $display("FAIL rstmid_refetch got %b/%0d/%h exp 0/2/12345678", h, reqn, rd); end
        chk++; if (miss_count !== 4'd1 || hit_count !== 4'd0) begin fails++; $display("FAIL rstmid_counts got %0d/%0d exp 0/1", hit_count, miss_count); end
    endtask

    task automatic test_saturation();
        logic [31:0] rd, erd; logic h, eh; int lat, reqn, bad;
        for (int k = 1; k <= 17; k++) begin
            model_step(1'b0, 15'h1234, '0, '0, erd, eh);
            access(1'b0, 15'h1234, '0, 32'h0BAD0BAD, 0, rd, h, lat, reqn, bad);
            chk++; if (h !== 1'b1 || hit_count !== 4'(mh)) begin fails++; $display("FAIL sat_step %0d got hit %b count %0d exp 1/%0d", k, h, hit_count, mh); end
        end
        chk++; if (hit_count !== 4'd15 || miss_count !== 4'd1) begin fails++; $display("FAIL sat_final got %0d/%0d exp 15/1", hit_count, miss_count); end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_conflict();
        test_store();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the direct-mapped data cache: owns the valid/tag/data line arrays, accepts one CPU load/store at a time and decides hit or miss.
- On a read miss it fetches the word from main memory over a req/ack handshake and fills the line.
- Stores are write-through with allocate.
- Sits between the CPU load/store port and the main-memory port; exports hit/miss statistics.

Parameters:
- ADDR_W, 15, CPU word-address width.
- INDEX_W, 12, line index width, 2^INDEX_W lines; TAG_W = ADDR_W - INDEX_W.
- DATA_W, 32, data word width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- cpu_req  input  1  request valid; sampled only in IDLE.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  ADDR_W  word address; index = [INDEX_W-1:0], tag = [ADDR_W-1:INDEX_W].
- cpu_wdata  input  DATA_W  store data.
- cpu_ready  output  1  one-cycle completion pulse.
- cpu_rdata  output  DATA_W  load result, valid with cpu_ready and held until next completion.
- cpu_hit  output  1  1 if the completed access hit; valid with cpu_ready.
- busy  output  1  high in every state except IDLE.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory word address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completion, one or more cycles.
- hit_count  output  CNT_W  saturating hit counter.
- miss_count  output  CNT_W  saturating miss counter.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE and every valid bit clears; tag/data arrays are not reset.
  - All outputs go to 0, including mem_req, so an in-flight memory transaction is abandoned immediately.
  - Counters go to 0.
- States:
  - IDLE: cpu_req=1 at an edge latches cpu_we/cpu_addr/cpu_wdata, then go to LOOKUP. Inputs are ignored in all other states.
  - LOOKUP (exactly 1 cycle): hit = valid[index] && tag[index]==latched tag.
    - Load hit: cpu_rdata <= data[index], cpu_hit <= 1, hit_count++, go to RESP.
    - Load miss: miss_count++, go to MEM_RD.
    - Store: counts hit or miss by the same compare, sets cpu_hit, then goes to MEM_WR.
  - MEM_RD: mem_req=1, mem_we=0, mem_addr=latched addr.
    - On the edge with mem_ack=1: valid/tag/data[index] <= 1/tag/mem_rdata, cpu_rdata <= mem_rdata, cpu_hit <= 0, go to RESP.
  - MEM_WR: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values.
    - On the edge with mem_ack=1: valid/tag/data[index] <= 1/tag/wdata (allocate, replacing any conflicting tag), go to RESP. cpu_rdata is unchanged.
  - RESP (1 cycle): cpu_ready=1, then go to IDLE.
- Memory handshake:
  - mem_req is registered and rises in the first cycle of MEM_RD/MEM_WR.
  - mem_addr/mem_we/mem_wdata stay stable while mem_req=1.
  - mem_req falls in the cycle after mem_ack is sampled.
  - mem_ack outside MEM_RD/MEM_WR is ignored.
  - No timeout; a stalled memory holds the controller in place.
- Latency, counting from the accepting edge E0:
  - Load hit: cpu_ready high in the cycle after E0+1, i.e. 2 cycles.
  - Miss or store: 2 cycles plus the memory wait (cycles until mem_ack) plus 1.
- Back-to-back: cpu_req held high through RESP is accepted at the edge ending RESP+IDLE. The minimum request spacing is 3 cycles (IDLE, LOOKUP, RESP).
- Conflicts: same index with a different tag is a miss; a fill replaces the line. There is no dirty state, because the cache is write-through.
- Counters saturate at 2^CNT_W-1 and never wrap; at most one counter increments per access.
- mem_wdata/mem_addr hold their last values when idle; only mem_req qualifies them.

Test Plan:
- Reset, then load 0x1234, mem_ack after 3 wait cycles with mem_rdata=0xDEADBEEF:
  - mem_req high with mem_addr=0x1234, mem_we=0.
  - cpu_ready with cpu_rdata=0xDEADBEEF, cpu_hit=0; miss_count=1.
- Repeat load 0x1234 → no mem_req; cpu_ready 2 cycles after accept with 0xDEADBEEF, cpu_hit=1; hit_count=1.
- Load 0x5234 (same index 0x234, tag 5) with mem_rdata=0x11111111, then load 0x1234:
  - Both miss (two mem_req transactions).
  - miss_count=3 and the second returns the fresh memory data.
- Store 0x0007 data 0xCAFEF00D:
  - mem_req/mem_we=1 with mem_wdata=0xCAFEF00D until ack.
  - A following load 0x0007 hits with 0xCAFEF00D and generates no mem_req.
- Assert rst low while mem_req=1 in MEM_RD:
  - mem_req=0 immediately, busy=0, counters 0.
  - After release, load 0x1234 misses (valid cleared).
- Preload hit_count near saturation via 2^CNT_W hits (or CNT_W=4 build, 17 hits) → hit_count stays 15, miss_count unchanged.
